// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encodings, default width and counter sizing for serial_add_ctrl
//
// Contents:
//   state_t        IDLE / SHIFT / DONE controller states
//   DEFAULT_WIDTH  default operand/result width
//   cnt_width()    bit counter width for a given operand width
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice;
    // the floor of 1 keeps the vector legal for tiny widths.
    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between a requester and serial_add_ctrl
//
// Signals:
//   start, abort   request / cancel strobes (requester -> adder)
//   a, b, cin      operands and carry-in (requester -> adder)
//   busy, done     status (adder -> requester)
//   sum, cout      result (adder -> requester)
// Modports: master = requester side, slave = adder side.
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, abort, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, abort, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder built from two half adders
//
// Ports:
//   a, b, cin  input  addend bits and carry-in
//   s          output sum bit
//   cout       output carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    // The two half-adder carries can never both be 1, so OR is exact.
    assign cout = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder
//
// Ports:
//   a, b  input  addend bits
//   s     output sum bit
//   c     output carry bit
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, one result bit per clock, LSB first
//
// Parameters:
//   WIDTH  operand/result width (2..32)
// Ports:
//   clk    input  system clock, rising edge
//   rst_n  input  asynchronous active-low reset (release assumed synchronous)
//   bus    slave  start/abort/a/b/cin in, busy/done/sum/cout out
// Computes {cout,sum} = a + b + cin through one shared full adder. done
// pulses for one cycle WIDTH+1 edges after the accepting edge; sum/cout
// hold until the next accepted start.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here, so start always wins
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        // new bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0]
                        sum_q <= {fa_s, sum_q[WIDTH-1:1]};
                        carry <= fa_c;
                        a_sr  <= a_sr >> 1;
                        b_sr  <= b_sr >> 1;
                        if (cnt == LAST_BIT) begin
                            cout_q <= fa_c;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Port clk SHALL be: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port start SHALL be: start  input  1  request to begin an addition; sampled on rising edge.
REQ-005 Port abort SHALL be: abort  input  1  synchronous cancel of an addition in progress.
REQ-006 Ports a, b SHALL be: a, b  input  WIDTH  operands; captured only on accepted start.
REQ-007 Port cin SHALL be: cin  input  1  carry-in; captured only on accepted start.
REQ-008 Port busy SHALL be: busy  output  1  high while in SHIFT or DONE state.
REQ-009 Port done SHALL be: done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 Ports sum, cout SHALL be: sum  output  WIDTH, cout  output  1  result registers.

Function
REQ-011 Block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, using a single shared full-adder cell.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; encoding from shared package.
REQ-013 IDLE: start=1 at an edge SHALL be accepted: load a, b into operand shift registers, carry flop <= cin, bit counter <= 0, sum <= 0, cout <= 0, go to SHIFT.
REQ-014 SHIFT: each edge SHALL shift the full-adder sum bit into sum MSB (sum shifts right), update carry flop with carry-out, shift operands right, increment counter.
REQ-015 SHIFT SHALL exit to DONE on the edge processing bit WIDTH-1; at that edge cout <= final carry.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: done SHALL be high during the cycle following the (WIDTH+1)th rising edge counted from and including the accepting edge (cycle N+WIDTH+1 for start sampled in cycle N).
REQ-018 start while busy=1 (SHIFT or DONE) SHALL be ignored; no queuing.
REQ-019 sum and cout SHALL hold their final values after DONE until the next accepted start.
REQ-020 abort=1 in SHIFT SHALL return to IDLE at that edge, no done pulse, sum and cout cleared to 0; abort in IDLE or DONE SHALL have no effect.
REQ-021 abort and start asserted together in IDLE: start SHALL win (abort ignored in IDLE).
REQ-022 Counter width SHALL be clog2(WIDTH) bits; no wrap-around may occur before the exit in REQ-015.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, operand registers=0, regardless of the clock.
REQ-024 Reset asserted mid-SHIFT SHALL discard the operation; after release the block SHALL accept a new start on the first rising edge.
REQ-025 Release of rst_n SHALL be assumed synchronous to clk by the integrator; no internal synchronizer.

Structure
REQ-026 Package serial_add_pkg SHALL hold the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH.
REQ-027 One sub-module full_adder SHALL be instantiated, built from two half_adder instances plus an OR of their carries; no other arithmetic in the controller.
REQ-028 All outputs SHALL be driven directly from flops.

Verification (WIDTH=8)
REQ-029 a=0x3C, b=0x0F, cin=0, start pulse -> done pulse exactly 9 cycles later, sum=0x4B, cout=0, busy high for 9 cycles.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-031 Start 0x10+0x20, then start with 0xFF+0xFF held high for cycles 2..6 -> single done, sum=0x30, cout=0; second request ignored.
REQ-032 Start 0x12+0x34, assert abort in 4th SHIFT cycle -> no done, busy low next cycle, sum=0x00, cout=0; immediate new start 0x01+0x01 -> sum=0x02.
REQ-033 Drop rst_n asynchronously (between edges) mid-SHIFT -> outputs 0 without a clock edge; after release, 0x80+0x80 cin=0 -> sum=0x00, cout=1.
REQ-034 Exhaustive self-check loop over all a, b, cin vs. a+b+cin reference model -> zero mismatches.
